// File: rtl/serial_pc_pkg.sv
// Shared types for the bit-serial program-counter controller: op encodings and FSM states.
package serial_pc_pkg;

  typedef enum logic [1:0] {
    OP_INC  = 2'b00,
    OP_REL  = 2'b01,
    OP_LOAD = 2'b10,
    OP_NOP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/serial_pc_fadder.sv
// One-bit full adder shared by the serial PC datapath (module fadder: a, b, c -> S, C).
module fadder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic S,
  output logic C
);

  assign S = a ^ b ^ c;
  assign C = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_pc_ctrl.sv
// Bit-serial program-counter controller: INC/REL computed LSB-first through one full adder.
// Optional ovf output is built when SERIAL_PC_OVF_EN is defined.
module serial_pc_ctrl
  import serial_pc_pkg::*;
#(
  parameter int             W         = 8,
  parameter logic [W-1:0]   RESET_VEC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] operand,
  output logic [W-1:0] pc,
  output logic         busy,
`ifdef SERIAL_PC_OVF_EN
  output logic         ovf,
`endif
  output logic         done
);

  localparam int CW = $clog2(W);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [W-1:0]    r_pc;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic            w_s;
  logic            w_c;
  logic            w_last;
  logic            w_go;

  assign w_go   = (r_state == ST_IDLE) && start;
  assign w_last = (r_cnt == CW'(W - 1));

  fadder u_fadder (
    .a (r_a[0]),
    .b (r_b[0]),
    .c (r_carry),
    .S (w_s),
    .C (w_c)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          case (op_e'(op))
            OP_INC, OP_REL: w_state_nxt = ST_SHIFT;
            default:        w_state_nxt = ST_DONE;
          endcase
        end
      end
      ST_SHIFT: if (w_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Control and architectural PC: reset-sensitive
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_VEC;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt <= '0;
            case (op_e'(op))
              OP_INC:  r_carry <= 1'b1;
              OP_REL:  r_carry <= 1'b0;
              OP_LOAD: r_pc    <= operand;
              default: ;
            endcase
          end
        end
        ST_SHIFT: begin
          r_carry <= w_c;
          r_cnt   <= r_cnt + 1'b1;
          // pc only changes once the full sum is assembled
          if (w_last) r_pc <= {w_s, r_sum[W-1:1]};
        end
        default: ;
      endcase
    end
  end

  // Serial operand/sum shift registers: data only, no reset needed
  always_ff @(posedge clk) begin
    if (w_go) begin
      r_a <= r_pc;
      r_b <= (op_e'(op) == OP_REL) ? operand : '0;
    end else if (r_state == ST_SHIFT) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_sum <= {w_s, r_sum[W-1:1]};
    end
  end

`ifdef SERIAL_PC_OVF_EN
  op_e r_op;

  always_ff @(posedge clk) begin
    if (w_go) r_op <= op_e'(op);
  end

  // INC reports unsigned carry-out; REL reports signed overflow (carry into MSB xor carry out)
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (w_go && (op_e'(op) == OP_LOAD || op_e'(op) == OP_NOP)) begin
      ovf <= 1'b0;
    end else if (r_state == ST_SHIFT && w_last) begin
      ovf <= (r_op == OP_INC) ? w_c : (r_carry ^ w_c);
    end
  end
`endif

  assign pc   = r_pc;
  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_serial_pc_ctrl.sv
// Directed self-checking bench for serial_pc_ctrl at W=8, RESET_VEC=0.
module tb_serial_pc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [7:0] operand;
  logic [7:0] pc;
  logic       busy;
  logic       done;
`ifdef SERIAL_PC_OVF_EN
  logic       ovf;
`endif

  int n_pass  = 0;
  int n_total = 0;

  serial_pc_ctrl #(.W(8), .RESET_VEC(8'h00)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .operand (operand),
    .pc      (pc),
    .busy    (busy),
`ifdef SERIAL_PC_OVF_EN
    .ovf     (ovf),
`endif
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_ovf(input string tag, input logic exp);
`ifdef SERIAL_PC_OVF_EN
    check(tag, ovf, exp);
`endif
  endtask

  // Issue one operation and wait (bounded) for its done pulse, then return to IDLE
  task automatic do_op(input logic [1:0] o, input logic [7:0] v);
    bit seen;
    op = o; operand = v; start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (done) seen = 1'b1;
      else tick();
    end
    check("done_seen", seen, 1);
    tick();
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; op = 2'b00; operand = 8'h00;
    tick(); tick();
    rst = 1'b0;
    check("rst_pc", pc, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_ovf("rst_ovf", 1'b0);

    // INC from 0: 8 SHIFT cycles with pc frozen, then one DONE cycle
    op = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      check($sformatf("inc_busy_c%0d", i), busy, 1);
      check($sformatf("inc_done_c%0d", i), done, (i == 9));
      check($sformatf("inc_pc_c%0d", i), pc, (i == 9) ? 8'h01 : 8'h00);
      tick();
    end
    check("inc_idle_busy", busy, 0);
    check("inc_idle_done", done, 0);
    check("inc_idle_pc", pc, 8'h01);

    // LOAD 0xFF has one-cycle latency
    op = 2'b10; operand = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    check("load_pc", pc, 8'hFF);
    check("load_done", done, 1);
    tick();
    check("load_idle", busy, 0);
    do_op(2'b00, 8'h00);
    check("inc_wrap_pc", pc, 8'h00);
    check_ovf("inc_wrap_ovf", 1'b1);

    do_op(2'b10, 8'h10);
    check_ovf("load_clr_ovf", 1'b0);
    do_op(2'b01, 8'hFE);
    check("rel_neg_pc", pc, 8'h0E);
    check_ovf("rel_neg_ovf", 1'b0);

    do_op(2'b10, 8'h3C);
    do_op(2'b01, 8'h05);
    check("rel_pos_pc", pc, 8'h41);

    do_op(2'b10, 8'h7F);
    do_op(2'b01, 8'h01);
    check("rel_sovf_pc", pc, 8'h80);
    check_ovf("rel_sovf_ovf", 1'b1);

    do_op(2'b10, 8'h55);
    do_op(2'b11, 8'hAA);
    check("nop_pc", pc, 8'h55);
    check_ovf("nop_ovf", 1'b0);

    // start pulsed mid-SHIFT must not launch a second operation
    do_op(2'b10, 8'h0E);
    op = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    op = 2'b10; operand = 8'hC3; start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      if (done) pulses++;
      tick();
    end
    check("ignore_start_pulses", pulses, 1);
    check("ignore_start_pc", pc, 8'h0F);

    // rst in 4th SHIFT cycle discards the partial INC
    op = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("midrst_in_shift", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_pc", pc, 8'h00);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) pulses++;
      tick();
    end
    check("midrst_no_done", pulses, 0);

    // rst wins over start in the same cycle
    do_op(2'b10, 8'h20);
    rst = 1'b1; op = 2'b10; operand = 8'h99; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_prio_busy", busy, 0);
    check("rst_prio_pc", pc, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_pc_ctrl.md
SERIAL_PC_CTRL -- requirements
Module: serial_pc_ctrl

Interface
REQ-001 Parameter W, default 8, program-counter width in bits (W >= 2).
REQ-002 Parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-003 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port start, input, 1, request pulse; sampled only in IDLE.
REQ-006 Port op, input, 2, operation: 00 INC, 01 REL, 10 LOAD, 11 NOP.
REQ-007 Port operand, input, W, relative offset (two's complement) for REL, or absolute value for LOAD; sampled with start.
REQ-008 Port pc, output, W, current program counter.
REQ-009 Port busy, output, 1, high whenever state is not IDLE.
REQ-010 Port done, output, 1, one-cycle completion pulse.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-012 In IDLE with start=1 at edge k, op and operand SHALL be latched; start SHALL be ignored in every other state.
REQ-013 INC and REL SHALL go to SHIFT at edge k with bit counter=0, a working copy of pc, and B = 0 / cin = 1 for INC, or B = operand / cin = 0 for REL.
REQ-014 SHIFT SHALL add one bit per cycle, LSB first, through a single full-adder instance, with a carry flop feeding the next bit.
REQ-015 SHIFT SHALL last exactly W cycles; at edge k+W the sum SHALL be written to pc and the state SHALL move to DONE.
REQ-016 pc SHALL hold its pre-operation value throughout SHIFT, with no partial results visible.
REQ-017 Arithmetic SHALL be modulo 2^W; wrap-around (0xFF+1 -> 0x00 at W=8) is legal and not an error.
REQ-018 LOAD SHALL write operand to pc at edge k and go directly to DONE (latency 1).
REQ-019 NOP SHALL go directly to DONE at edge k with pc unchanged.
REQ-020 done SHALL be 1 for exactly the one cycle spent in DONE, after which the FSM SHALL return to IDLE unconditionally.
REQ-021 A start held high SHALL begin a new operation in the first IDLE cycle; back-to-back operations SHALL therefore be separated by at least one IDLE cycle.

Reset
REQ-022 rst=1 SHALL force state IDLE, pc=RESET_VEC, busy=0, done=0, carry=0 and counter=0 at the next edge, including mid-SHIFT; the partial result SHALL be discarded.
REQ-023 rst SHALL take priority over start in the same cycle.

Configuration
REQ-024 With SERIAL_PC_OVF_EN defined, output port ovf (1 bit) SHALL exist; it SHALL be set to the final carry-out of an INC, or to the signed overflow of a REL, at the pc-write edge, cleared by LOAD/NOP/rst, and held otherwise.
REQ-025 Without SERIAL_PC_OVF_EN, ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 The op encodings and the FSM state enum SHALL reside in package serial_pc_pkg.
REQ-027 The one-bit add SHALL instantiate the existing fadder sub-module (a, b, c -> S, C) exactly once; no other adder SHALL be inferred for the PC datapath.

Verification (W=8, RESET_VEC=0)
REQ-028 rst high for 2 cycles -> pc=0x00, busy=0, done=0 (ovf=0 if enabled).
REQ-029 INC from 0x00 -> busy high for 9 cycles; done high for exactly 1 cycle, in the 9th cycle after start; pc=0x01, unchanged (0x00) during SHIFT.
REQ-030 LOAD 0xFF, then INC -> pc=0xFF after 1 cycle, then 0x00; ovf=1 if enabled.
REQ-031 LOAD 0x10, then REL 0xFE -> pc=0x0E; ovf=0.
REQ-032 start pulsed during SHIFT -> ignored; exactly one done pulse.
REQ-033 rst asserted in the 4th SHIFT cycle of an INC -> pc=0x00, IDLE next cycle, no done pulse.
